// File: rtl/sprite_pkg.sv
// Shared sprite-memory geometry and loader state type.
// Used by the sprite loader (write side) and the draw logic (read side) so that
// both agree on the address layout: sprite*SPRITE_PIXELS + row*SPRITE_W + col.
package sprite_pkg;

  localparam int unsigned SPRITE_W         = 20;
  localparam int unsigned SPRITE_H         = 20;
  localparam int unsigned SPRITE_PIXELS    = SPRITE_W * SPRITE_H;
  localparam int unsigned NUM_SPRITES      = 38;
  localparam int unsigned BG_SPRITE        = 37;
  // Two 4-bit pixels per byte; SPRITE_W is even so a byte never straddles a row.
  localparam int unsigned BYTES_PER_SPRITE = SPRITE_PIXELS / 2;

  typedef enum logic [1:0] {IDLE, ACCEPT, WR_LO, WR_HI} loader_state_t;

  // One past the last slot a command touches; 7 bits so 63 + 63 cannot wrap.
  function automatic logic [6:0] slot_end(input logic [5:0] first, input logic [5:0] count);
    return {1'b0, first} + {1'b0, count};
  endfunction

endpackage

// File: rtl/sprite_loader_if.sv
// Command, byte-stream and memory-write bundle of the sprite loader.
//   start, start_sprite, n_sprites : load command (host -> loader)
//   data_in, data_valid, data_ready: packed-pixel byte stream with handshake
//   write_address, write_data, we  : sprite memory write port (loader -> RAM)
//   busy, done, error              : command status
// master = host/boot stream side, slave = loader.
interface sprite_loader_if #(
  parameter int unsigned ADDR_W = 16
) ();

  logic              start;
  logic [5:0]        start_sprite;
  logic [5:0]        n_sprites;
  logic [7:0]        data_in;
  logic              data_valid;
  logic              data_ready;
  logic [ADDR_W-1:0] write_address;
  logic [3:0]        write_data;
  logic              we;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, start_sprite, n_sprites, data_in, data_valid,
    input  data_ready, write_address, write_data, we, busy, done, error
  );

  modport slave (
    input  start, start_sprite, n_sprites, data_in, data_valid,
    output data_ready, write_address, write_data, we, busy, done, error
  );

endinterface

// File: rtl/sprite_loader.sv
// Sprite loader: unpacks a byte stream of 4-bit colour pairs into sprite memory.
// One command loads n_sprites consecutive 20x20 slots starting at start_sprite.
// Ports:
//   Clk   : system clock
//   Reset : synchronous, active-high reset
//   bus   : sprite_loader_if.slave (command, byte handshake, write port, status)
// Every output is a register; the next-state logic computes the value each
// output must have while the FSM sits in its next state.
module sprite_loader
  import sprite_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  sprite_loader_if.slave bus
);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] total_q, total_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [7:0]        byte_q, byte_d;

  logic              data_ready_q, data_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    total_d      = total_q;
    pix_d        = pix_q;
    byte_d       = byte_q;
    data_ready_d = 1'b0;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (slot_end(bus.start_sprite, bus.n_sprites) > 7'(NUM_SPRITES)) begin
            error_d = 1'b1;
          end else if (bus.n_sprites == 6'd0) begin
            done_d = 1'b1;
          end else begin
            // Only multiplies in the design; per-pixel addressing is base + counter.
            base_d       = ADDR_W'(bus.start_sprite) * ADDR_W'(SPRITE_PIXELS);
            total_d      = ADDR_W'(bus.n_sprites) * ADDR_W'(SPRITE_PIXELS);
            pix_d        = '0;
            busy_d       = 1'b1;
            data_ready_d = 1'b1;
            state_d      = ACCEPT;
          end
        end
      end

      ACCEPT: begin
        data_ready_d = 1'b1;
        if (bus.data_valid && data_ready_q) begin
          // Set up the low-nibble write that is visible while in WR_LO.
          byte_d       = bus.data_in;
          we_d         = 1'b1;
          wdata_d      = bus.data_in[3:0];
          addr_d       = base_q + pix_q;
          pix_d        = pix_q + ADDR_W'(1);
          data_ready_d = 1'b0;
          state_d      = WR_LO;
        end
      end

      WR_LO: begin
        // Set up the high-nibble write that is visible while in WR_HI.
        we_d    = 1'b1;
        wdata_d = byte_q[7:4];
        addr_d  = base_q + pix_q;
        pix_d   = pix_q + ADDR_W'(1);
        state_d = WR_HI;
      end

      WR_HI: begin
        // pix_q already counts the high-nibble write currently on the port.
        if (pix_q == total_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          data_ready_d = 1'b1;
          state_d      = ACCEPT;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      base_q       <= '0;
      total_q      <= '0;
      pix_q        <= '0;
      byte_q       <= '0;
      data_ready_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      total_q      <= total_d;
      pix_q        <= pix_d;
      byte_q       <= byte_d;
      data_ready_q <= data_ready_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.data_ready    = data_ready_q;
  assign bus.we            = we_q;
  assign bus.write_address = addr_q;
  assign bus.write_data    = wdata_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.error         = error_q;

endmodule

// File: tb/tb_sprite_loader.sv
// Self-checking bench for sprite_loader: random byte streams and random
// data_valid gaps, checked against a write-log model (pixel i of a command goes
// to start*400 + i, low nibble of each byte first).
module tb_sprite_loader;
  import sprite_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned MEM_WORDS = NUM_SPRITES * SPRITE_PIXELS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sprite_loader_if #(.ADDR_W(AW)) bus ();

  sprite_loader #(.ADDR_W(AW)) dut (
    .Clk  (clk),
    .Reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [3:0]    d;
  } wr_t;

  wr_t        wlog[$];
  logic [7:0] tx[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt, err_cnt, ready_cnt, overlap_cnt;
  int last_we_cyc, done_cyc;

  always @(posedge clk) cyc++;

  // Passive monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      wlog.push_back('{a: bus.write_address, d: bus.write_data});
      last_we_cyc = cyc;
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.error === 1'b1) err_cnt++;
    if (bus.data_ready === 1'b1) ready_cnt++;
    if (bus.done === 1'b1 && bus.error === 1'b1) overlap_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    wlog.delete();
    tx.delete();
    done_cnt    = 0;
    err_cnt     = 0;
    ready_cnt   = 0;
    last_we_cyc = -1;
    done_cyc    = -1;
  endtask

  task automatic do_start(input logic [5:0] first, input logic [5:0] count);
    bus.start        = 1'b1;
    bus.start_sprite = first;
    bus.n_sprites    = count;
    tick();
    bus.start = 1'b0;
  endtask

  // Sends random bytes; returns right after the last one is accepted.
  task automatic send_bytes(input int nbytes, input bit rand_valid);
    for (int i = 0; i < nbytes; i++) begin
      logic [7:0] b;
      int waited;
      bit acc;
      b = 8'($urandom);
      waited = 0;
      acc = 1'b0;
      bus.data_in = b;
      while (!acc) begin
        bus.data_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        acc = bus.data_valid && (bus.data_ready === 1'b1);
        tick();
        waited++;
        if (!acc && waited > 60) begin
          vectors++;
          miscompares++;
          $display("FAIL handshake_timeout: byte %0d not accepted after %0d cycles, want accept",
                   i, waited);
          bus.data_valid = 1'b0;
          return;
        end
      end
      tx.push_back(b);
    end
    bus.data_valid = 1'b0;
  endtask

  // Bounded wait for the done pulse; leaves time at edge+1 of the done cycle.
  task automatic wait_done(input int limit, output bit ok);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    ok = (bus.done === 1'b1);
  endtask

  // Model: index of first log entry disagreeing with the expected write sequence, -1 if none.
  function automatic int log_first_bad(input int base);
    for (int i = 0; i < wlog.size(); i++) begin
      logic [7:0] b;
      logic [3:0] nib;
      if (i / 2 >= tx.size()) return i;
      b = tx[i / 2];
      nib = (i % 2 == 1) ? b[7:4] : b[3:0];
      if (wlog[i].a !== AW'(base + i) || wlog[i].d !== nib) return i;
    end
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    vectors++; if (bus.data_ready !== 1'b0) begin miscompares++;
      $display("FAIL reset_data_ready: got %b want 0", bus.data_ready); end
    vectors++; if (bus.we !== 1'b0) begin miscompares++;
      $display("FAIL reset_we: got %b want 0", bus.we); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++;
      $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0 || bus.error !== 1'b0) begin miscompares++;
      $display("FAIL reset_done_error: got %b/%b want 0/0", bus.done, bus.error); end
    vectors++; if (bus.write_address !== '0 || bus.write_data !== 4'h0) begin miscompares++;
      $display("FAIL reset_write_port: got %0d/%h want 0/0", bus.write_address, bus.write_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    int bad;
    clear();
    do_start(6'd5, 6'd1);
    vectors++; if (bus.data_ready !== 1'b1 || bus.busy !== 1'b1) begin miscompares++;
      $display("FAIL single_accept: ready/busy %b/%b want 1/1", bus.data_ready, bus.busy); end
    bus.data_in = 8'hA3;
    bus.data_valid = 1'b1;
    tx.push_back(8'hA3);
    tick();
    bus.data_valid = 1'b0;
    vectors++; if (bus.we !== 1'b1 || bus.write_address !== 16'd2000 || bus.write_data !== 4'h3)
    begin miscompares++;
      $display("FAIL single_lo: we %b addr %0d data %h want 1 2000 3",
               bus.we, bus.write_address, bus.write_data); end
    vectors++; if (bus.data_ready !== 1'b0) begin miscompares++;
      $display("FAIL single_ready_lo: got %b want 0", bus.data_ready); end
    tick();
    vectors++; if (bus.we !== 1'b1 || bus.write_address !== 16'd2001 || bus.write_data !== 4'hA)
    begin miscompares++;
      $display("FAIL single_hi: we %b addr %0d data %h want 1 2001 a",
               bus.we, bus.write_address, bus.write_data); end
    tick();
    vectors++; if (bus.data_ready !== 1'b1 || bus.we !== 1'b0) begin miscompares++;
      $display("FAIL single_ready_back: ready/we %b/%b want 1/0", bus.data_ready, bus.we); end
    send_bytes(BYTES_PER_SPRITE - 1, 1'b0);
    wait_done(20, ok);
    vectors++; if (!ok || bus.busy !== 1'b0) begin miscompares++;
      $display("FAIL single_done: done seen %b busy %b want 1/0", ok, bus.busy); end
    tick();
    vectors++; if (bus.done !== 1'b0 || done_cnt != 1) begin miscompares++;
      $display("FAIL single_done_pulse: done %b count %0d want 0/1", bus.done, done_cnt); end
    vectors++; if (done_cyc != last_we_cyc + 1) begin miscompares++;
      $display("FAIL single_done_timing: done cycle %0d want %0d", done_cyc, last_we_cyc + 1);
    end
    vectors++; if (wlog.size() != SPRITE_PIXELS || wlog[wlog.size()-1].a !== 16'd2399)
    begin miscompares++;
      $display("FAIL single_last_addr: writes %0d want 400 ending at 2399", wlog.size()); end
    bad = log_first_bad(5 * SPRITE_PIXELS);
    vectors++; if (bad != -1) begin miscompares++;
      $display("FAIL single_log: first bad write index %0d want -1", bad); end
  endtask

  task automatic test_error();
    clear();
    do_start(6'd37, 6'd2);
    vectors++; if (bus.error !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0)
    begin miscompares++;
      $display("FAIL error_pulse: error/done/busy %b/%b/%b want 1/0/0",
               bus.error, bus.done, bus.busy); end
    bus.data_valid = 1'b1;
    bus.data_in = 8'h5C;
    repeat (20) tick();
    bus.data_valid = 1'b0;
    vectors++; if (wlog.size() != 0 || ready_cnt != 0) begin miscompares++;
      $display("FAIL error_quiet: writes %0d ready cycles %0d want 0/0", wlog.size(), ready_cnt);
    end
    vectors++; if (err_cnt != 1) begin miscompares++;
      $display("FAIL error_once: error cycles %0d want 1", err_cnt); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int cov[MEM_WORDS];
    int out_range, not_once, rebuilt_bad;
    clear();
    do_start(6'd36, 6'd2);
    send_bytes(2 * BYTES_PER_SPRITE, 1'b1);
    wait_done(20, ok);
    vectors++; if (!ok) begin miscompares++;
      $display("FAIL bp_done: done seen %b want 1", ok); end
    tick();
    foreach (cov[i]) cov[i] = 0;
    out_range = 0;
    foreach (wlog[i]) begin
      if (int'(wlog[i].a) >= 14400 && int'(wlog[i].a) < 15200) cov[wlog[i].a]++;
      else out_range++;
    end
    not_once = 0;
    for (int a = 14400; a < 15200; a++) if (cov[a] != 1) not_once++;
    vectors++; if (out_range != 0 || not_once != 0) begin miscompares++;
      $display("FAIL bp_coverage: out of range %0d, addresses not written once %0d want 0/0",
               out_range, not_once); end
    // Rebuild the byte stream from consecutive low/high writes.
    rebuilt_bad = 0;
    for (int j = 0; j < tx.size(); j++) begin
      if (2 * j + 1 >= wlog.size()) rebuilt_bad++;
      else if ({wlog[2*j+1].d, wlog[2*j].d} !== tx[j]) rebuilt_bad++;
    end
    vectors++; if (rebuilt_bad != 0 || wlog.size() != 2 * tx.size()) begin miscompares++;
      $display("FAIL bp_rebuild: bad bytes %0d, writes %0d want 0 and %0d",
               rebuilt_bad, wlog.size(), 2 * tx.size()); end
    vectors++; if (done_cnt != 1 || err_cnt != 0) begin miscompares++;
      $display("FAIL bp_status: done %0d error %0d want 1/0", done_cnt, err_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bad;
    clear();
    do_start(6'd10, 6'd1);
    send_bytes(50, 1'b0);
    reset = 1'b1;
    tick();
    vectors++; if (bus.we !== 1'b0 || bus.busy !== 1'b0 || bus.data_ready !== 1'b0)
    begin miscompares++;
      $display("FAIL midreset_idle: we/busy/ready %b/%b/%b want 0/0/0",
               bus.we, bus.busy, bus.data_ready); end
    reset = 1'b0;
    tick();
    clear();
    do_start(6'd0, 6'd1);
    send_bytes(1, 1'b1);
    vectors++; if (bus.we !== 1'b1 || bus.write_address !== 16'd0) begin miscompares++;
      $display("FAIL midreset_restart: we %b addr %0d want 1 0", bus.we, bus.write_address); end
    send_bytes(BYTES_PER_SPRITE - 1, 1'b1);
    wait_done(20, ok);
    tick();
    bad = log_first_bad(0);
    vectors++; if (!ok || bad != -1 || wlog.size() != SPRITE_PIXELS) begin miscompares++;
      $display("FAIL midreset_reload: done %b first bad %0d writes %0d want 1 -1 400",
               ok, bad, wlog.size()); end
  endtask

  task automatic test_zero_and_ignore();
    bit ok;
    int bad;
    clear();
    do_start(6'd3, 6'd0);
    vectors++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.error !== 1'b0)
    begin miscompares++;
      $display("FAIL zero_done: done/busy/error %b/%b/%b want 1/0/0",
               bus.done, bus.busy, bus.error); end
    repeat (5) tick();
    vectors++; if (wlog.size() != 0 || done_cnt != 1) begin miscompares++;
      $display("FAIL zero_quiet: writes %0d done cycles %0d want 0/1", wlog.size(), done_cnt);
    end
    clear();
    do_start(6'd2, 6'd1);
    send_bytes(30, 1'b1);
    do_start(6'd10, 6'd3);
    vectors++; if (bus.busy !== 1'b1 || bus.error !== 1'b0) begin miscompares++;
      $display("FAIL ignore_start: busy/error %b/%b want 1/0", bus.busy, bus.error); end
    do_start(6'd37, 6'd5);
    send_bytes(BYTES_PER_SPRITE - 30, 1'b1);
    wait_done(20, ok);
    tick();
    bad = log_first_bad(2 * SPRITE_PIXELS);
    vectors++; if (!ok || bad != -1 || wlog.size() != SPRITE_PIXELS) begin miscompares++;
      $display("FAIL ignore_load: done %b first bad %0d writes %0d want 1 -1 400",
               ok, bad, wlog.size()); end
    vectors++; if (done_cnt != 1 || err_cnt != 0) begin miscompares++;
      $display("FAIL ignore_status: done %0d error %0d want 1/0", done_cnt, err_cnt); end
  endtask

  initial begin
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.start_sprite = '0;
    bus.n_sprites    = '0;
    bus.data_in      = '0;
    bus.data_valid   = 1'b0;
    overlap_cnt      = 0;
    clear();
    test_reset();
    test_single();
    test_error();
    test_backpressure();
    test_reset_mid();
    test_zero_and_ignore();
    vectors++; if (overlap_cnt != 0) begin miscompares++;
      $display("FAIL done_error_overlap: %0d cycles want 0", overlap_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
